// File: rtl/register_file_sb.sv
// Multi-port register file with per-register busy scoreboard.
// Combinational reads with optional write bypass and hardwired zero register.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG    = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    localparam int SELECT_WIDTH = $clog2(NUM_REG),
    localparam int COUNT_WIDTH  = $clog2(NUM_REG + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_READ-1:0][SELECT_WIDTH-1:0]   i_rd_addr,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]     o_rd_data,
    output logic [NUM_READ-1:0]                     o_rd_busy,
    input  logic                                    i_wr_en,
    input  logic [SELECT_WIDTH-1:0]                 i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                   i_wr_data,
    input  logic                                    i_alloc_en,
    input  logic [SELECT_WIDTH-1:0]                 i_alloc_addr,
    input  logic                                    i_flush,
    output logic [COUNT_WIDTH-1:0]                  o_busy_count
);

    logic [DATA_WIDTH-1:0]  mem [NUM_REG];
    logic [NUM_REG-1:0]     busy;
    logic [NUM_REG-1:0]     busy_nxt;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] count_nxt;
    logic                   wr_ok;
    logic                   alloc_ok;

    function automatic logic addr_ok(input logic [SELECT_WIDTH-1:0] a);
        return (32'(a) < NUM_REG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok    = i_wr_en && addr_ok(i_wr_addr);
    assign alloc_ok = i_alloc_en && addr_ok(i_alloc_addr);

    // Busy priority: flush over alloc over write-clear.
    always_comb begin
        busy_nxt = busy;
        if (i_flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_ok)
                busy_nxt[i_wr_addr] = 1'b0;
            if (alloc_ok)
                busy_nxt[i_alloc_addr] = 1'b1;
        end
    end

    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < NUM_REG; i++)
            count_nxt = count_nxt + COUNT_WIDTH'(busy_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REG; i++)
                mem[i] <= '0;
            busy  <= '0;
            count <= '0;
        end else begin
            if (wr_ok)
                mem[i_wr_addr] <= i_wr_data;
            busy  <= busy_nxt;
            count <= count_nxt;
        end
    end

    assign o_busy_count = count;

    // Bypass is gated by rst_n so outputs stay 0 while reset is held.
    always_comb begin
        for (int p = 0; p < NUM_READ; p++) begin
            o_rd_data[p] = '0;
            o_rd_busy[p] = 1'b0;
            if (addr_ok(i_rd_addr[p])) begin
                if ((BYPASS != 0) && rst_n && wr_ok
                    && (i_rd_addr[p] == i_wr_addr)) begin
                    o_rd_data[p] = i_wr_data;
                end else begin
                    o_rd_data[p] = mem[i_rd_addr[p]];
                    o_rd_busy[p] = busy[i_rd_addr[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: bypass and non-bypass instances
// share stimulus; expectations are queued and checked by a monitor.
module tb_register_file_sb;

    localparam int DW = 32;
    localparam int NR = 6;
    localparam int SW = 3;
    localparam int CW = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0][SW-1:0]     rd_addr;
    logic [1:0][DW-1:0]     a_data, b_data;
    logic [1:0]             a_busy, b_busy;
    logic [CW-1:0]          a_count, b_count;
    logic                   wr_en;
    logic [SW-1:0]          wr_addr;
    logic [DW-1:0]          wr_data;
    logic                   alloc_en;
    logic [SW-1:0]          alloc_addr;
    logic                   flush;

    typedef struct {
        string       name;
        int          kind;
        int          dut;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event sample;

    always #5 clk = ~clk;

    register_file_sb #(
        .DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(2),
        .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_rd_addr(rd_addr), .o_rd_data(a_data), .o_rd_busy(a_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_flush(flush), .o_busy_count(a_count)
    );

    register_file_sb #(
        .DATA_WIDTH(DW), .NUM_REG(NR), .NUM_READ(2),
        .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_rd_addr(rd_addr), .o_rd_data(b_data), .o_rd_busy(b_busy),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .i_flush(flush), .o_busy_count(b_count)
    );

    function automatic logic [31:0] actual(int kind, int dut, int port);
        logic [31:0] v;
        v = '0;
        case (kind)
            0: v = (dut == 0) ? a_data[port] : b_data[port];
            1: v = 32'((dut == 0) ? a_busy[port] : b_busy[port]);
            default: v = 32'((dut == 0) ? a_count : b_count);
        endcase
        return v;
    endfunction

    task automatic push(string name, int kind, int dut, int port,
                        logic [31:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.dut = dut;
        e.port = port; e.val = val;
        q.push_back(e);
    endtask

    // Same expectation on both instances.
    task automatic push2(string name, int kind, int port, logic [31:0] val);
        push(name, kind, 0, port, val);
        push(name, kind, 1, port, val);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    endtask

    task automatic alloc(logic [SW-1:0] r);
        idle();
        alloc_en = 1'b1; alloc_addr = r;
        step();
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clk or sample);
            while (q.size() > 0) begin
                e = q.pop_front();
                a = actual(e.kind, e.dut, e.port);
                n_cmp++;
                if (a !== e.val) begin
                    n_bad++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h",
                             e.name, e.dut, e.port, a, e.val);
                end
            end
        end
    end

    initial begin : stim
        rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        alloc_addr = '0;
        idle();
        rd_addr[0] = 3'd1; rd_addr[1] = 3'd2;
        step();
        push2("rst_data0", 0, 0, 0);
        push2("rst_data1", 0, 1, 0);
        push2("rst_busy0", 1, 0, 0);
        push2("rst_count", 2, 0, 0);
        step();

        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hAA;
        step();
        wr_addr = 3'd1; wr_data = 32'hBB;
        step();
        idle();
        push2("readback_r1", 0, 0, 32'hBB);
        push2("readback_r2", 0, 1, 32'hAA);
        step();

        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h1234;
        rd_addr[1] = 3'd5;
        push(("bypass_same"), 0, 0, 1, 32'h1234);
        push(("nobypass_old"), 0, 1, 1, 32'h0);
        step();
        idle();
        push2("write_next", 0, 1, 32'h1234);
        step();

        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFF;
        alloc_en = 1'b1; alloc_addr = 3'd0;
        rd_addr[0] = 3'd0;
        push2("r0_same", 0, 0, 0);
        step();
        idle();
        push2("r0_data", 0, 0, 0);
        push2("r0_busy", 1, 0, 0);
        push2("r0_count", 2, 0, 0);
        step();

        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'hCC;
        rd_addr[1] = 3'd7;
        push2("oor_same", 0, 1, 0);
        step();
        idle();
        rd_addr[0] = 3'd1;
        push2("oor_read", 0, 1, 0);
        push2("oor_r1_kept", 0, 0, 32'hBB);
        push2("oor_count", 2, 0, 0);
        step();

        alloc(3'd3);
        idle();
        rd_addr[0] = 3'd3;
        push2("alloc_busy", 1, 0, 1);
        push2("alloc_count", 2, 0, 1);
        push2("alloc_data", 0, 0, 0);
        step();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h55;
        push("wb_bypass_data", 0, 0, 0, 32'h55);
        push("wb_bypass_busy", 1, 0, 0, 0);
        push("wb_nobyp_data", 0, 1, 0, 32'h0);
        push("wb_nobyp_busy", 1, 1, 0, 1);
        push2("wb_count_same", 2, 0, 1);
        step();
        idle();
        push2("wb_data", 0, 0, 32'h55);
        push2("wb_busy", 1, 0, 0);
        push2("wb_count", 2, 0, 0);
        step();

        alloc(3'd4);
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h77;
        alloc_en = 1'b1; alloc_addr = 3'd4;
        step();
        idle();
        rd_addr[0] = 3'd4;
        push2("coll_data", 0, 0, 32'h77);
        push2("coll_busy", 1, 0, 1);
        push2("coll_count", 2, 0, 1);
        step();
        alloc(3'd1);
        alloc(3'd2);
        alloc(3'd3);
        idle();
        rd_addr[0] = 3'd1; rd_addr[1] = 3'd3;
        push2("four_count", 2, 0, 4);
        push2("four_busy_r1", 1, 0, 1);
        push2("four_busy_r3", 1, 1, 1);
        flush = 1'b1; alloc_en = 1'b1; alloc_addr = 3'd5;
        step();
        idle();
        rd_addr[0] = 3'd4; rd_addr[1] = 3'd5;
        push2("flush_count", 2, 0, 0);
        push2("flush_busy_r4", 1, 0, 0);
        push2("flush_busy_r5", 1, 1, 0);
        push2("flush_data_r5", 0, 1, 32'h1234);
        step();

        alloc(3'd1);
        alloc(3'd3);
        alloc(3'd4);
        idle();
        rd_addr[0] = 3'd2; rd_addr[1] = 3'd3;
        push2("pre_rst_count", 2, 0, 3);
        push2("pre_rst_r2", 0, 0, 32'hAA);
        push2("pre_rst_busy", 1, 1, 1);
        step();
        rst_n = 1'b0;
        #1;
        push2("async_count", 2, 0, 0);
        push2("async_r2", 0, 0, 0);
        push2("async_busy", 1, 1, 0);
        ->sample;
        step();

        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'h99;
        rd_addr[1] = 3'd1;
        step();
        idle();
        push2("post_rst_r2", 0, 0, 32'h99);
        push2("post_rst_r1", 0, 1, 0);
        push2("post_rst_count", 2, 0, 0);
        step();
        step();

        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
